// File: rtl/spike_train_decoder.sv
// Spike train decoder: counts spike rising edges per fixed window and tracks the
// most recent inter-spike interval, presenting each window's result on valid/ready.
module spike_train_decoder #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 16,
    parameter int ISI_W         = 24
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rate_count,
    output logic [ISI_W-1:0] last_isi,
    output logic             isi_known,
    output logic             count_sat,
    output logic             overrun
);

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_spike_q;
    logic [WIN_W-1:0] r_win_ctr;
    logic [CNT_W-1:0] r_spike_ctr;
    logic             r_sat;
    logic [ISI_W-1:0] r_isi_ctr;
    logic [ISI_W-1:0] r_last_isi_int;
    logic             r_isi_known_int;

    logic             r_out_valid;
    logic [CNT_W-1:0] r_rate_count;
    logic [ISI_W-1:0] r_last_isi;
    logic             r_isi_known;
    logic             r_count_sat;
    logic             r_overrun;

    logic             w_rise;
    logic             w_measuring;
    logic             w_win_end;
    logic             w_isi_event;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;
    logic [ISI_W-1:0] w_isi_inc;
    logic [ISI_W-1:0] w_last_isi_next;
    logic             w_isi_known_next;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_next = S_ARMED;
            S_ARMED: begin
                if (!enable)     w_state_next = S_IDLE;
                else if (w_rise) w_state_next = S_RUN;
            end
            S_RUN:   if (!enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Window-end values must already include a rise in the final window cycle.
    always_comb begin
        w_rise      = spike_in & ~r_spike_q;
        w_measuring = (r_state != S_IDLE) && enable;
        w_win_end   = w_measuring && (r_win_ctr == WIN_LAST);
        w_isi_event = (r_state == S_RUN) && w_rise;

        w_cnt_next = r_spike_ctr;
        w_sat_next = r_sat;
        if (w_rise) begin
            if (r_spike_ctr == CNT_MAX) begin
                w_sat_next = 1'b1;
            end else begin
                w_cnt_next = r_spike_ctr + CNT_W'(1);
            end
        end

        w_isi_inc = (r_isi_ctr == ISI_MAX) ? r_isi_ctr : r_isi_ctr + ISI_W'(1);

        w_last_isi_next  = r_last_isi_int;
        w_isi_known_next = r_isi_known_int;
        if (w_isi_event) begin
            w_last_isi_next  = w_isi_inc;
            w_isi_known_next = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_spike_q       <= 1'b0;
            r_win_ctr       <= '0;
            r_spike_ctr     <= '0;
            r_sat           <= 1'b0;
            r_isi_ctr       <= '0;
            r_last_isi_int  <= '0;
            r_isi_known_int <= 1'b0;
        end else begin
            r_spike_q <= spike_in;
            if (!w_measuring) begin
                r_win_ctr       <= '0;
                r_spike_ctr     <= '0;
                r_sat           <= 1'b0;
                r_isi_ctr       <= '0;
                r_isi_known_int <= 1'b0;
            end else begin
                r_win_ctr       <= w_win_end ? '0 : r_win_ctr + WIN_W'(1);
                r_spike_ctr     <= w_win_end ? '0 : w_cnt_next;
                r_sat           <= w_win_end ? 1'b0 : w_sat_next;
                r_last_isi_int  <= w_last_isi_next;
                r_isi_known_int <= w_isi_known_next;
                if (w_rise) begin
                    r_isi_ctr <= '0;
                end else if (r_state == S_RUN) begin
                    r_isi_ctr <= w_isi_inc;
                end
            end
        end
    end

    // A new window result only replaces the held one if the old one is gone or leaving.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_rate_count <= '0;
            r_last_isi   <= '0;
            r_isi_known  <= 1'b0;
            r_count_sat  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_win_end) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid  <= 1'b1;
                    r_rate_count <= w_cnt_next;
                    r_count_sat  <= w_sat_next;
                    r_last_isi   <= w_last_isi_next;
                    r_isi_known  <= w_isi_known_next;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if ((r_state == S_IDLE) && enable) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign rate_count = r_rate_count;
    assign last_isi   = r_last_isi;
    assign isi_known  = r_isi_known;
    assign count_sat  = r_count_sat;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed bench for spike_train_decoder: 16-cycle windows, one full-width DUT and
// one with a 2-bit count field sharing the same stimulus.
module tb_spike_train_decoder;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic reset, enable, spike_in, out_ready;

    logic        a_out_valid, a_isi_known, a_count_sat, a_overrun;
    logic [15:0] a_rate_count;
    logic [23:0] a_last_isi;

    logic        b_out_valid, b_isi_known, b_count_sat, b_overrun;
    logic [1:0]  b_rate_count;
    logic [23:0] b_last_isi;

    spike_train_decoder #(.WINDOW_CYCLES(16), .CNT_W(16), .ISI_W(24)) u_dut_a (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .rate_count (a_rate_count),
        .last_isi   (a_last_isi),
        .isi_known  (a_isi_known),
        .count_sat  (a_count_sat),
        .overrun    (a_overrun)
    );

    spike_train_decoder #(.WINDOW_CYCLES(16), .CNT_W(2), .ISI_W(24)) u_dut_b (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .rate_count (b_rate_count),
        .last_isi   (b_last_isi),
        .isi_known  (b_isi_known),
        .count_sat  (b_count_sat),
        .overrun    (b_overrun)
    );

    int   total = 0;
    int   bad   = 0;
    logic ov_at1;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One 16-cycle window; bit k of each mask drives cycle k. Captures out_valid after cycle 0.
    task automatic run_window(input logic [15:0] pat, input logic [15:0] rdy);
        for (int k = 0; k < 16; k++) begin
            spike_in  = pat[k];
            out_ready = rdy[k];
            step();
            if (k == 0) ov_at1 = a_out_valid;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] rate, input logic [31:0] isi,
                              input logic known, input logic sat, input logic ovr);
        chk({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        chk({tag, ".rate"},  32'(a_rate_count), rate);
        chk({tag, ".isi"},   32'(a_last_isi), isi);
        chk({tag, ".known"}, 32'(a_isi_known), 32'(known));
        chk({tag, ".sat"},   32'(a_count_sat), 32'(sat));
        chk({tag, ".ovr"},   32'(a_overrun), 32'(ovr));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; spike_in = 1'b1; out_ready = 1'b0;
        ov_at1 = 1'b0;
        repeat (3) step();
        chk("rst.valid", 32'(a_out_valid), 32'd0);
        chk("rst.rate",  32'(a_rate_count), 32'd0);
        chk("rst.isi",   32'(a_last_isi), 32'd0);
        chk("rst.known", 32'(a_isi_known), 32'd0);
        chk("rst.sat",   32'(a_count_sat), 32'd0);
        chk("rst.ovr",   32'(a_overrun), 32'd0);

        // Release with spike_in still high: the held level must not count.
        reset = 1'b0; out_ready = 1'b1;
        step();
        run_window(16'h0007, 16'hFFFF);
        chk_result("w1", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        run_window(16'h1111, 16'hFFFF);
        chk("w2.pulse", 32'(ov_at1), 32'd0);
        chk_result("w2", 32'd4, 32'd4, 1'b1, 1'b0, 1'b0);

        run_window(16'h1111, 16'hFFFF);
        chk("w3.pulse", 32'(ov_at1), 32'd0);
        chk_result("w3", 32'd4, 32'd4, 1'b1, 1'b0, 1'b0);

        run_window(16'h07FE, 16'hFFFF);
        chk_result("w4.level", 32'd1, 32'd5, 1'b1, 1'b0, 1'b0);

        run_window(16'h0204, 16'hFFFF);
        chk_result("w5.isi7", 32'd2, 32'd7, 1'b1, 1'b0, 1'b0);

        run_window(16'h0888, 16'h0000);
        chk("w6.held", 32'(ov_at1), 32'd1);
        chk_result("w6.drop", 32'd2, 32'd7, 1'b1, 1'b0, 1'b1);

        run_window(16'h0020, 16'h0001);
        chk("w7.xfer", 32'(ov_at1), 32'd0);
        chk_result("w7", 32'd1, 32'd10, 1'b1, 1'b0, 1'b1);

        run_window(16'h8000, 16'hFFFF);
        chk_result("w8.last", 32'd1, 32'd26, 1'b1, 1'b0, 1'b1);

        run_window(16'h0001, 16'hFFFF);
        chk_result("w9.cont", 32'd0, 32'd26, 1'b1, 1'b0, 1'b1);

        run_window(16'h0001, 16'hFFFF);
        chk_result("w10.first", 32'd1, 32'd17, 1'b1, 1'b0, 1'b1);

        run_window(16'h02AA, 16'hFFFF);
        chk_result("w11", 32'd5, 32'd2, 1'b1, 1'b0, 1'b1);
        chk("w11.b_rate", 32'(b_rate_count), 32'd3);
        chk("w11.b_sat",  32'(b_count_sat), 32'd1);

        run_window(16'h0000, 16'hFFFF);
        chk("w12.b_rate", 32'(b_rate_count), 32'd0);
        chk("w12.b_sat",  32'(b_count_sat), 32'd0);

        // Drop enable at window cycle 9: partial window yields nothing.
        for (int k = 0; k < 9; k++) begin
            spike_in = (k == 3); out_ready = 1'b1;
            step();
        end
        enable = 1'b0; spike_in = 1'b0;
        repeat (21) step();
        chk("w13.novalid", 32'(a_out_valid), 32'd0);
        chk("w13.ovr_idle", 32'(a_overrun), 32'd1);

        enable = 1'b1;
        step();
        chk("rearm.ovr", 32'(a_overrun), 32'd0);

        run_window(16'h0010, 16'hFFFF);
        chk("w14.rate",  32'(a_rate_count), 32'd1);
        chk("w14.known", 32'(a_isi_known), 32'd0);

        run_window(16'h0010, 16'hFFFF);
        chk_result("w15", 32'd1, 32'd16, 1'b1, 1'b0, 1'b0);

        // Pending result survives enable=0 until taken.
        enable = 1'b0; out_ready = 1'b0; spike_in = 1'b0;
        repeat (3) step();
        chk("hold.valid", 32'(a_out_valid), 32'd1);
        chk("hold.rate",  32'(a_rate_count), 32'd1);
        out_ready = 1'b1;
        step();
        chk("take.valid", 32'(a_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
